xcore_exe_shift_arb: RTL and testbench
======================================

XCORE_EXE_SHIFT_ARB -- requirements
Module: xcore_exe_shift_arb

Interface
REQ-001 SHALL have parameter: RR_INIT, 0, requester preferred first after reset (0 or 1).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req0_valid in 1, req0_ready out 1, req0_data in 32, req0_shamt in 5, req0_op in 2 (requester 0).
REQ-005 SHALL have ports: req1_valid in 1, req1_ready out 1, req1_data in 32, req1_shamt in 5, req1_op in 2 (requester 1).
REQ-006 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_id out 1, rsp_data out 32, rsp_err out 1 (shared result).
REQ-007 SHALL have shifter ports: sh_data out 32, sh_a_l out 1 (1 logical, 0 arithmetic), sh_l_r out 1 (1 left, 0 right), sh_shamt out 5, sh_dout in 32 (combinational return).
REQ-008 op encoding SHALL be: 00 SLL, 01 SRL, 10 SRA, 11 ROR.

Function
REQ-009 FSM states SHALL be IDLE, PASS1, PASS2, RESP; only one operation in flight.
REQ-010 reqN_ready SHALL be 1 only in IDLE and only for the granted requester.
REQ-011 Grant in IDLE: single valid requester wins; both valid -> requester equal to prio register wins.
REQ-012 On accept (valid&ready), prio SHALL flip to the other requester; data, shamt, op, id SHALL be registered; state -> PASS1.
REQ-013 PASS1 SHALL drive shifter from registers (SLL: l_r=1,a_l=1; SRL: l_r=0,a_l=1; SRA: l_r=0,a_l=0; ROR: SRL by shamt), capture sh_dout, then go to RESP (or PASS2 for ROR).
REQ-014 PASS2 (ROR only) SHALL drive SLL by (32-shamt) mod 32 on the original operand; result = PASS1 value OR PASS2 value; shamt=0 SHALL yield the operand unchanged.
REQ-015 Latency: accept in cycle N -> rsp_valid high at N+2 (SLL/SRL/SRA) or N+3 (ROR).
REQ-016 RESP SHALL hold rsp_valid, rsp_id, rsp_data, rsp_err stable until rsp_ready; on rsp_valid&rsp_ready state -> IDLE; new accept no earlier than the following cycle.
REQ-017 Outside PASS1/PASS2, sh_data, sh_shamt SHALL be 0 and sh_a_l=1, sh_l_r=0.
REQ-018 rsp_valid SHALL be 0 in every state except RESP.

Reset
REQ-019 rst SHALL immediately force state IDLE, prio=RR_INIT, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, all operand registers 0.
REQ-020 rst asserted mid-operation SHALL abort it with no response; the requester SHALL reissue.
REQ-021 reqN_ready SHALL be 0 while rst is high.

Configuration
REQ-022 Macro XCORE_SHIFT_ROTATE_EN SHALL enable ROR (op 11) via PASS2 as per REQ-013/014; rsp_err always 0.
REQ-023 Without XCORE_SHIFT_ROTATE_EN, PASS2 SHALL not exist; op 11 SHALL be accepted, skip the shifter, respond at N+2 with rsp_data=0, rsp_err=1.

Verification
REQ-024 req0 SLL data=0x0000_0001 shamt=31 -> rsp at N+2, rsp_id=0, rsp_data=0x8000_0000, rsp_err=0.
REQ-025 req1 SRA data=0x8000_00F0 shamt=4 vs SRL same -> 0xF800_000F and 0x0800_000F.
REQ-026 Both valid every cycle from reset, RR_INIT=0 -> grants alternate 0,1,0,1; rsp_id sequence matches; no starvation.
REQ-027 rsp_ready held low 5 cycles in RESP -> outputs stable, both reqN_ready=0; release -> IDLE next cycle.
REQ-028 ROR data=0x1234_5678 shamt=8 -> with macro rsp_data=0x7812_3456 at N+3, shamt=0 -> 0x1234_5678; without macro -> rsp_data=0, rsp_err=1 at N+2.
REQ-029 rst pulsed during PASS1 -> no rsp_valid, prio=RR_INIT, next accept proceeds normally.

Source files
------------

// File: rtl/xcore_exe_shift_arb.sv
// rtl/xcore_exe_shift_arb.sv - two-requester round-robin front end for an external barrel shifter
// Optional rotate support: define XCORE_SHIFT_ROTATE_EN to enable ROR (op 11) through a second shifter pass.
module xcore_exe_shift_arb #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    input  logic [1:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] sh_data,
    output logic        sh_a_l,
    output logic        sh_l_r,
    output logic [4:0]  sh_shamt,
    input  logic [31:0] sh_dout
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

`ifdef XCORE_SHIFT_ROTATE_EN
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, PASS1, RESP} state_t;
`endif

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [1:0]  op_q, op_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        grant0, grant1;

    // Grant is only meaningful in IDLE; a tie goes to the requester named by prio.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !prio_q);
        grant1 = req1_valid && (!req0_valid || prio_q);
    end

    assign req0_ready = !rst && (state_q == IDLE) && grant0;
    assign req1_ready = !rst && (state_q == IDLE) && grant1;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;

    always_comb begin
        sh_data  = 32'd0;
        sh_shamt = 5'd0;
        sh_a_l   = 1'b1;
        sh_l_r   = 1'b0;
        case (state_q)
            PASS1: begin
                case (op_q)
                    OP_SLL: begin
                        sh_data  = data_q;
                        sh_shamt = shamt_q;
                        sh_l_r   = 1'b1;
                    end
                    OP_SRL: begin
                        sh_data  = data_q;
                        sh_shamt = shamt_q;
                    end
                    OP_SRA: begin
                        sh_data  = data_q;
                        sh_shamt = shamt_q;
                        sh_a_l   = 1'b0;
                    end
                    default: begin
`ifdef XCORE_SHIFT_ROTATE_EN
                        sh_data  = data_q;
                        sh_shamt = shamt_q;
`endif
                    end
                endcase
            end
`ifdef XCORE_SHIFT_ROTATE_EN
            // Left half of the rotate: 5-bit wraparound gives (32 - shamt) mod 32.
            PASS2: begin
                sh_data  = data_q;
                sh_shamt = 5'd0 - shamt_q;
                sh_l_r   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        data_d      = data_q;
        shamt_d     = shamt_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    data_d   = grant1 ? req1_data  : req0_data;
                    shamt_d  = grant1 ? req1_shamt : req0_shamt;
                    op_d     = grant1 ? req1_op    : req0_op;
                    rsp_id_d = grant1;
                    prio_d   = grant0;
                    state_d  = PASS1;
                end
            end
            PASS1: begin
                rsp_data_d  = sh_dout;
                rsp_err_d   = 1'b0;
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                if (op_q == OP_ROR) begin
`ifdef XCORE_SHIFT_ROTATE_EN
                    state_d     = PASS2;
                    rsp_valid_d = 1'b0;
`else
                    rsp_data_d  = 32'd0;
                    rsp_err_d   = 1'b1;
`endif
                end
            end
`ifdef XCORE_SHIFT_ROTATE_EN
            PASS2: begin
                rsp_data_d  = rsp_data_q | sh_dout;
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= RR_INIT;
            data_q      <= 32'd0;
            shamt_q     <= 5'd0;
            op_q        <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            data_q      <= data_d;
            shamt_q     <= shamt_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_xcore_exe_shift_arb.sv
// tb/tb_xcore_exe_shift_arb.sv - self-checking bench for xcore_exe_shift_arb with a behavioural shifter and reference model
module tb_xcore_exe_shift_arb;
`ifdef XCORE_SHIFT_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] sh_data, sh_dout;
    logic        sh_a_l, sh_l_r;
    logic [4:0]  sh_shamt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    bit          busy;
    bit          mprio;
    int          resp_cyc;
    logic        exp_id;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] f_data [2];
    logic [4:0]  f_shamt [2];
    logic [1:0]  f_op [2];
    int          ngrant [2];

    xcore_exe_shift_arb #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_shamt(req1_shamt), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .sh_data(sh_data), .sh_a_l(sh_a_l), .sh_l_r(sh_l_r),
        .sh_shamt(sh_shamt), .sh_dout(sh_dout)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (sh_l_r)      sh_dout = sh_data << sh_shamt;
        else if (sh_a_l) sh_dout = sh_data >> sh_shamt;
        else             sh_dout = 32'($signed(sh_data) >>> sh_shamt);
    end

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        logic [63:0] dd;
        case (op)
            2'd0: return d << s;
            2'd1: return d >> s;
            2'd2: return 32'($signed(d) >>> s);
            default: begin
                dd = {d, d} >> s;
                return ROT ? dd[31:0] : 32'd0;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic new_fields(input int r);
        int k;
        k = $urandom_range(0, 3);
        f_data[r]  = $urandom;
        f_shamt[r] = (k == 0) ? 5'd0 : (k == 1) ? 5'd31 : 5'($urandom_range(0, 31));
        f_op[r]    = 2'($urandom_range(0, 3));
    endtask

    task automatic drive(input logic v0, input logic v1);
        req0_valid = v0; req0_data = f_data[0]; req0_shamt = f_shamt[0]; req0_op = f_op[0];
        req1_valid = v1; req1_data = f_data[1]; req1_shamt = f_shamt[1]; req1_op = f_op[1];
    endtask

    task automatic chk_idle_shifter(input string tag);
        chk({tag, "_sh_data"}, sh_data, 32'd0);
        chk({tag, "_sh_shamt"}, 32'(sh_shamt), 32'd0);
        chk({tag, "_sh_a_l"}, 32'(sh_a_l), 32'd1);
        chk({tag, "_sh_l_r"}, 32'(sh_l_r), 32'd0);
    endtask

    // One directed transaction, optionally stalling the response for 'hold' cycles.
    task automatic do_op(input string tag, input bit r, input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] op, input logic [31:0] ed, input bit ee, input int elat, input int hold);
        int lat;
        f_data[r] = d; f_shamt[r] = s; f_op[r] = op;
        drive(!r, r);
        rsp_ready = 1'b0;
        #1;
        chk({tag, "_ready"}, 32'(r ? req1_ready : req0_ready), 32'd1);
        chk({tag, "_other_ready"}, 32'(r ? req0_ready : req1_ready), 32'd0);
        tick();
        drive(1'b0, 1'b0);
        lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            #1;
            if (rsp_valid) lat = k;
            else tick();
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(r));
        chk({tag, "_rsp_data"}, rsp_data, ed);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(ee));
        for (int h = 0; h < hold; h++) begin
            drive(1'b1, 1'b1);
            #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_data"}, rsp_data, ed);
            chk({tag, "_hold_id"}, 32'(rsp_id), 32'(r));
            chk({tag, "_hold_err"}, 32'(rsp_err), 32'(ee));
            chk({tag, "_hold_rdy"}, {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
        end
        drive(1'b0, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk({tag, "_released"}, 32'(rsp_valid), 32'd0);
        mprio = !r;
    endtask

    // Abort an operation while it sits in its first shifter pass.
    task automatic reset_mid(input string tag, input bit r);
        f_data[r] = 32'hA5A5_0001; f_shamt[r] = 5'd3; f_op[r] = 2'd0;
        drive(!r, r);
        rsp_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(r ? req1_ready : req0_ready), 32'd1);
        tick();
        drive(1'b1, 1'b1);
        rst = 1'b1;
        #1;
        chk({tag, "_rst_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rst_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rst_data"}, rsp_data, 32'd0);
        chk({tag, "_rst_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rst_rdy"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        chk_idle_shifter({tag, "_rst"});
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk({tag, "_no_rsp"}, 32'(rsp_valid), 32'd0);
            tick();
        end
        drive(1'b1, 1'b1);
        #1;
        chk({tag, "_prio_r0"}, 32'(req0_ready), 32'd1);
        chk({tag, "_prio_r1"}, 32'(req1_ready), 32'd0);
        drive(1'b0, 1'b0);
        tick();
    endtask

    // Random traffic checked cycle by cycle against a transaction-level model.
    task automatic rand_phase(input int n, input bit both, input bit always_ready);
        for (int i = 0; i < n; i++) begin
            logic v0, v1, rr, g0, g1, ev;
            int w;
            v0 = both || ($urandom_range(0, 1) == 1);
            v1 = both || ($urandom_range(0, 1) == 1);
            rr = always_ready || ($urandom_range(0, 2) != 0);
            drive(v0, v1);
            rsp_ready = rr;
            #1;
            g0 = !busy && v0 && (!v1 || mprio == 1'b0);
            g1 = !busy && v1 && (!v0 || mprio == 1'b1);
            ev = busy && (cyc >= resp_cyc);
            chk("rnd_req0_ready", 32'(req0_ready), 32'(g0));
            chk("rnd_req1_ready", 32'(req1_ready), 32'(g1));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(ev));
            if (ev) begin
                chk("rnd_rsp_id", 32'(rsp_id), 32'(exp_id));
                chk("rnd_rsp_data", rsp_data, exp_data);
                chk("rnd_rsp_err", 32'(rsp_err), 32'(exp_err));
            end
            if (!(busy && cyc < resp_cyc)) chk_idle_shifter("rnd");
            if (ev && rr) busy = 1'b0;
            if (g0 || g1) begin
                w = g1 ? 1 : 0;
                busy = 1'b1;
                mprio = !g1;
                exp_id = g1;
                exp_data = ref_res(f_op[w], f_data[w], f_shamt[w]);
                exp_err = (f_op[w] == 2'd3) && !ROT;
                resp_cyc = cyc + ((f_op[w] == 2'd3 && ROT) ? 3 : 2);
                ngrant[w]++;
                new_fields(w);
            end
            tick();
        end
    endtask

    initial begin
        int diff;
        rst = 1'b1;
        rsp_ready = 1'b0;
        f_data[0] = 32'hFFFF_FFFF; f_shamt[0] = 5'd1; f_op[0] = 2'd0;
        f_data[1] = 32'hFFFF_FFFF; f_shamt[1] = 5'd1; f_op[1] = 2'd0;
        drive(1'b1, 1'b1);
        @(negedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk_idle_shifter("reset");
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0);
        tick();

        do_op("sll31", 1'b0, 32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000, 1'b0, 2, 0);
        do_op("sra4",  1'b1, 32'h8000_00F0, 5'd4,  2'd2, 32'hF800_000F, 1'b0, 2, 5);
        do_op("srl4",  1'b1, 32'h8000_00F0, 5'd4,  2'd1, 32'h0800_000F, 1'b0, 2, 1);
        do_op("ror8",  1'b0, 32'h1234_5678, 5'd8,  2'd3, ROT ? 32'h7812_3456 : 32'd0, !ROT, ROT ? 3 : 2, 2);
        do_op("ror0",  1'b1, 32'h1234_5678, 5'd0,  2'd3, ROT ? 32'h1234_5678 : 32'd0, !ROT, ROT ? 3 : 2, 0);
        do_op("sll0",  1'b0, 32'hDEAD_BEEF, 5'd0,  2'd0, 32'hDEAD_BEEF, 1'b0, 2, 0);

        reset_mid("rmid1", 1'b1);
        reset_mid("rmid0", 1'b0);

        busy = 1'b0;
        mprio = 1'b0;
        ngrant[0] = 0;
        ngrant[1] = 0;
        new_fields(0);
        new_fields(1);
        rand_phase(40, 1'b1, 1'b1);
        diff = ngrant[0] - ngrant[1];
        chk("alternate_balance", 32'((diff >= -1 && diff <= 1) && ngrant[0] > 3), 32'd1);

        rand_phase(400, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
